// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the
// exception/interrupt controller.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ENTER   = 2'b01,
    HANDLER = 2'b10,
    RETURN  = 2'b11
  } state_e;

  localparam logic [1:0] ID_SYSCALL  = 2'b00;
  localparam logic [1:0] ID_INVALID  = 2'b01;
  localparam logic [1:0] ID_OVERFLOW = 2'b10;
  localparam logic [1:0] ID_EXTINT   = 2'b11;

  localparam logic [31:0] VEC_ADDR_DEF = 32'h0000_0180;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: 4->2 priority encoder, bit 0 highest,
// with a valid flag when any request is present.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [3:0] req_i,
  output logic [1:0] id_o,
  output logic       vld_o
);

  // lowest set bit wins
  always_comb begin
    id_o  = ID_SYSCALL;
    vld_o = |req_i;
    if (req_i[0])      id_o = ID_SYSCALL;
    else if (req_i[1]) id_o = ID_INVALID;
    else if (req_i[2]) id_o = ID_OVERFLOW;
    else if (req_i[3]) id_o = ID_EXTINT;
  end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: sticky pending capture, priority
// select and ENTER/HANDLER/RETURN handshake FSM.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_ADDR = VEC_ADDR_DEF,
  parameter int          NSRC        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic        invalid,
  input  logic        overflow,
  input  logic        ext_int,
  input  logic [3:0]  mask,
  input  logic        rfe,
  output logic        int_req,
  output logic [1:0]  id,
  output logic        epc_we,
  output logic        epc_re,
  output logic        pc_sel,
  output logic [31:0] vec_pc,
  output logic        in_handler,
  output logic [3:0]  pending,
  output logic        spurious_rfe
);

  state_e            state_q, state_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [1:0]        svc_q, svc_d;
  logic              spur_q, spur_d;

  logic [NSRC-1:0]   src;
  logic [NSRC-1:0]   clr;
  logic [1:0]        enc_id;
  logic              enc_vld;

  assign src = {ext_int, overflow, invalid, syscall};
  assign clr = 4'b0001 << svc_q;

  exc_prio_enc u_enc (
    .req_i (pend_q & ~mask),
    .id_o  (enc_id),
    .vld_o (enc_vld)
  );

  // pending: a new event on the clear edge survives
  always_comb begin
    pend_d = pend_q | src;
    if (state_q == RETURN)
      pend_d = (pend_q & ~clr) | src;
  end

  assign spur_d = rfe & (state_q != HANDLER);

  // handshake FSM next-state and strobes
  always_comb begin
    state_d    = state_q;
    svc_d      = svc_q;
    int_req    = 1'b0;
    id         = svc_q;
    epc_we     = 1'b0;
    epc_re     = 1'b0;
    pc_sel     = 1'b0;
    in_handler = 1'b0;
    unique case (state_q)
      IDLE: begin
        int_req = enc_vld;
        id      = enc_id;
        if (enc_vld) begin
          svc_d   = enc_id;
          state_d = ENTER;
        end
      end
      ENTER: begin
        epc_we  = 1'b1;
        pc_sel  = 1'b1;
        state_d = HANDLER;
      end
      HANDLER: begin
        in_handler = 1'b1;
        if (rfe) state_d = RETURN;
      end
      RETURN: begin
        epc_re  = 1'b1;
        pc_sel  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // registered state, pending, service id, spurious flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      svc_q   <= ID_SYSCALL;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      svc_q   <= svc_d;
      spur_q  <= spur_d;
    end
  end

  assign pending      = pend_q;
  assign spurious_rfe = spur_q;
  assign vec_pc       = VECTOR_ADDR;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed plus random stimulus,
// reference model feeds a scoreboard queue.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        syscall = 1'b0, invalid = 1'b0;
  logic        overflow = 1'b0, ext_int = 1'b0;
  logic [3:0]  mask = 4'h0;
  logic        rfe = 1'b0;
  logic        int_req, epc_we, epc_re, pc_sel;
  logic        in_handler, spurious_rfe;
  logic [1:0]  id;
  logic [31:0] vec_pc;
  logic [3:0]  pending;

  exception_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .syscall      (syscall),
    .invalid      (invalid),
    .overflow     (overflow),
    .ext_int      (ext_int),
    .mask         (mask),
    .rfe          (rfe),
    .int_req      (int_req),
    .id           (id),
    .epc_we       (epc_we),
    .epc_re       (epc_re),
    .pc_sel       (pc_sel),
    .vec_pc       (vec_pc),
    .in_handler   (in_handler),
    .pending      (pending),
    .spurious_rfe (spurious_rfe)
  );

  always #5 clk = ~clk;

  // observation: pend, int_req, id, we, re, sel,
  // in_handler, spurious, vec_pc
  typedef logic [44:0] obs_t;
  obs_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: phase 0 waiting, 1 entering,
  // 2 servicing, 3 returning
  int       m_phase = 0;
  bit [3:0] m_pend  = 0;
  int       m_svc   = 0;
  bit       m_spur  = 0;

  function automatic int first_set(bit [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i;
    return 0;
  endfunction

  function automatic obs_t expect_obs(bit [3:0] mk);
    bit [3:0] av;
    bit       req;
    int       eid;
    av  = m_pend & ~mk;
    req = (m_phase == 0) && (av != 0);
    eid = (m_phase == 0) ? first_set(av) : m_svc;
    return {m_pend, req, 2'(eid),
            m_phase == 1, m_phase == 3,
            m_phase == 1 || m_phase == 3,
            m_phase == 2, m_spur,
            32'h0000_0180};
  endfunction

  // drive one cycle of inputs at negedge, advance the
  // model across the following posedge, queue expectation
  task automatic step(bit [3:0] s, bit [3:0] mk,
                      bit r, bit rst_n);
    bit [3:0] av;
    int       nphase;
    @(negedge clk);
    {ext_int, overflow, invalid, syscall} = s;
    mask  = mk;
    rfe   = r;
    reset = rst_n;
    if (!rst_n) begin
      m_phase = 0; m_pend = 0;
      m_svc = 0;   m_spur = 0;
    end else begin
      av     = m_pend & ~mk;
      nphase = m_phase;
      m_spur = r && (m_phase != 2);
      if (m_phase == 3)
        m_pend = m_pend & ~(4'b1 << m_svc);
      m_pend = m_pend | s;
      case (m_phase)
        0: if (av != 0) begin
             m_svc = first_set(av);
             nphase = 1;
           end
        1: nphase = 2;
        2: if (r) nphase = 3;
        default: nphase = 0;
      endcase
      m_phase = nphase;
    end
    exp_q.push_back(expect_obs(mk));
  endtask

  task automatic idle(int n, bit [3:0] mk);
    for (int i = 0; i < n; i++) step(0, mk, 0, 1);
  endtask

  // monitor: compare DUT outputs once per cycle
  initial begin
    obs_t got, want;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = {pending, int_req, id, epc_we, epc_re,
                pc_sel, in_handler, spurious_rfe, vec_pc};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL obs cyc%0d got=%h exp=%h",
                   cyc, got, want);
        end
      end
    end
  end

  initial begin
    bit [3:0] s, mk;
    bit       r;
    // reset held
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    // single overflow pulse
    step(4'b0100, 0, 0, 1);
    idle(4, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    // syscall and ext_int together
    step(4'b1001, 0, 0, 1);
    idle(3, 0);
    step(0, 0, 1, 1);
    idle(4, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    // masked ext_int, then unmask
    step(4'b1000, 4'b1000, 0, 1);
    idle(3, 4'b1000);
    idle(3, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    // rfe in idle
    step(0, 0, 1, 1);
    idle(2, 0);
    // overflow re-asserted on return edge
    step(4'b0100, 0, 0, 1);
    idle(3, 0);
    step(0, 0, 1, 1);
    step(4'b0100, 0, 0, 1);
    idle(4, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    // reset mid-handler with syscall+invalid pending
    step(4'b0011, 0, 0, 1);
    idle(3, 0);
    step(0, 0, 0, 0);
    idle(3, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    step(0, 0, 1, 1);
    idle(3, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s  = 4'(($urandom_range(0, 7) == 0) ?
              $urandom_range(0, 15) : 0);
      mk = 4'(($urandom_range(0, 3) == 0) ?
              $urandom_range(0, 15) : 0);
      r  = ($urandom_range(0, 3) == 0);
      step(s, mk, r, $urandom_range(0, 199) != 0);
    end
    idle(2, 0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
